// File: rtl/internal_pps_gen.sv
// internal_pps_gen: free-running internal PPS generator.
// Counts clock cycles into one-second periods. It emits a PPS pulse, a
// one-cycle strobe and a completed-second count. Phase corrections requested
// through the register block (pps_add / pps_flag toggle) are applied at
// second boundaries by lengthening or shortening individual seconds.
// Optional build macro INTERNAL_PPS_SLEW_EN: when it is defined, each second's
// correction is also limited to MAX_SLEW cycles, so a large correction is
// spread over several seconds.
module internal_pps_gen #(
  parameter int unsigned CLK_HZ       = 156250000,
  parameter int unsigned PULSE_CYCLES = 15625000,
  parameter int unsigned MAX_SLEW     = 1000
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        enable,
  input  logic [32:0] pps_add,
  input  logic        pps_flag,
  output logic        pps_out,
  output logic        pps_stb,
  output logic [31:0] sec_count,
  output logic        adj_busy
);

`ifdef INTERNAL_PPS_SLEW_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  localparam logic [33:0] CLK34     = 34'(CLK_HZ);
  localparam logic [33:0] PULSE34   = 34'(PULSE_CYCLES);
  localparam logic [33:0] SHORT_MAX = 34'(CLK_HZ - PULSE_CYCLES - 1);
  localparam logic [33:0] SLEW34    = 34'(MAX_SLEW);

  logic [33:0] cnt_q, cnt_d;
  logic [33:0] term_q, term_d;
  logic        pendDir_q, pendDir_d;
  logic [31:0] pendMag_q, pendMag_d;
  logic        flag_q;
  logic        primed_q;
  logic [31:0] sec_q, sec_d;
  logic        stb_q, stb_d;
  logic        out_q, out_d;
  logic        busy_q, busy_d;

  logic        request;
  logic        boundary;
  logic [33:0] stepLimit;
  logic [33:0] step;
  logic [33:0] nextLen;
  logic [33:0] magRemain;

  // Work out the next-second length, then the counter, pending and output updates
  always_comb begin
    request   = primed_q && (pps_flag != flag_q);
    boundary  = enable && (cnt_q == term_q);

    stepLimit = pendDir_q ? SHORT_MAX : CLK34;
    step      = {2'b00, pendMag_q};
    if (step > stepLimit) begin
      step = stepLimit;
    end
    if (SLEW_EN && (step > SLEW34)) begin
      step = SLEW34;
    end
    nextLen   = pendDir_q ? (CLK34 - step) : (CLK34 + step);
    magRemain = {2'b00, pendMag_q} - step;

    cnt_d     = cnt_q;
    term_d    = term_q;
    sec_d     = sec_q;
    pendDir_d = pendDir_q;
    pendMag_d = pendMag_q;

    if (!enable) begin
      cnt_d = '0;
    end else if (boundary) begin
      cnt_d     = '0;
      sec_d     = sec_q + 32'd1;
      term_d    = nextLen - 34'd1;
      pendMag_d = magRemain[31:0];
    end else begin
      cnt_d = cnt_q + 34'd1;
    end

    // A new request overrides whatever the boundary just left in pending
    if (request) begin
      pendDir_d = pps_add[32];
      pendMag_d = pps_add[31:0];
    end

    stb_d  = enable && (cnt_q == '0);
    out_d  = enable && (cnt_q < PULSE34);
    busy_d = (pendMag_d != '0);
  end

  // State registers; reset discards any pending correction
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cnt_q     <= '0;
      term_q    <= CLK34 - 34'd1;
      pendDir_q <= 1'b0;
      pendMag_q <= '0;
      flag_q    <= 1'b0;
      primed_q  <= 1'b0;
      sec_q     <= '0;
      stb_q     <= 1'b0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      term_q    <= term_d;
      pendDir_q <= pendDir_d;
      pendMag_q <= pendMag_d;
      flag_q    <= pps_flag;
      primed_q  <= 1'b1;
      sec_q     <= sec_d;
      stb_q     <= stb_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
    end
  end

  assign pps_out   = out_q;
  assign pps_stb   = stb_q;
  assign sec_count = sec_q;
  assign adj_busy  = busy_q;

endmodule

// File: tb/tb_internal_pps_gen.sv
// Testbench for internal_pps_gen with CLK_HZ=100, PULSE_CYCLES=10, MAX_SLEW=4.
// A second-level reference model checks every output on every cycle.
// Strobe-interval tables check the expected second lengths directly.
module tb_internal_pps_gen;

  localparam int CLK_HZ   = 100;
  localparam int PULSE    = 10;
  localparam int MAX_SLEW = 4;

`ifdef INTERNAL_PPS_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        areset = 1'b0;
  logic        enable = 1'b0;
  logic        ppsFlag = 1'b0;
  logic [32:0] ppsAdd = '0;
  logic        ppsOut;
  logic        ppsStb;
  logic [31:0] secCount;
  logic        adjBusy;

  int checks = 0;
  int failures = 0;

  // Reference model: position within the current second, its length,
  // the pending correction and the last seen flag level
  int          mPhase;
  int          mLen;
  logic        mDir;
  longint      mMag;
  logic        mFlag;
  logic        mPrimed;
  logic [31:0] mSec;
  logic        expStb;
  logic        expOut;
  logic        expBusy;

  typedef struct {
    logic [32:0] add;
    int          len0;
    int          len1;
    int          len2;
    int          len3;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  internal_pps_gen #(
    .CLK_HZ(CLK_HZ),
    .PULSE_CYCLES(PULSE),
    .MAX_SLEW(MAX_SLEW)
  ) dut (
    .clk(clk),
    .areset(areset),
    .enable(enable),
    .pps_add(ppsAdd),
    .pps_flag(ppsFlag),
    .pps_out(ppsOut),
    .pps_stb(ppsStb),
    .sec_count(secCount),
    .adj_busy(adjBusy)
  );

  task automatic checkEq(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    mPhase  = 0;
    mLen    = CLK_HZ;
    mDir    = 1'b0;
    mMag    = 0;
    mFlag   = 1'b0;
    mPrimed = 1'b0;
    mSec    = '0;
    expStb  = 1'b0;
    expOut  = 1'b0;
    expBusy = 1'b0;
  endfunction

  // Advance the model by one clock given the inputs seen at that edge
  function automatic void modelStep(input logic en, input logic flag, input logic [32:0] add);
    longint step;
    longint limit;
    expStb = en && (mPhase == 0);
    expOut = en && (mPhase < PULSE);
    if (en) begin
      if (mPhase == mLen - 1) begin
        limit = mDir ? longint'(CLK_HZ - PULSE - 1) : longint'(CLK_HZ);
        step  = (mMag > limit) ? limit : mMag;
        if (SLEW && step > MAX_SLEW) step = MAX_SLEW;
        mLen   = mDir ? int'(CLK_HZ - step) : int'(CLK_HZ + step);
        mMag   = mMag - step;
        mSec   = mSec + 32'd1;
        mPhase = 0;
      end else begin
        mPhase++;
      end
    end else begin
      mPhase = 0;
    end
    if (mPrimed && (flag != mFlag)) begin
      mDir = add[32];
      mMag = longint'(add[31:0]);
    end
    mFlag   = flag;
    mPrimed = 1'b1;
    expBusy = (mMag != 0);
  endfunction

  task automatic checkOutput();
    checkEq("pps_stb", longint'(ppsStb), longint'(expStb));
    checkEq("pps_out", longint'(ppsOut), longint'(expOut));
    checkEq("sec_count", longint'(secCount), longint'(mSec));
    checkEq("adj_busy", longint'(adjBusy), longint'(expBusy));
  endtask

  // One clock: inputs were set at the preceding falling edge
  task automatic applyStimulus();
    @(posedge clk);
    modelStep(enable, ppsFlag, ppsAdd);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  // Run until the next strobe; n is the number of clocks taken
  task automatic waitStrobe(output int n);
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!ppsStb && n < 500);
    if (!ppsStb) begin
      checks++;
      failures++;
      $display("[TB] FAIL strobe_timeout actual=no_strobe expected=strobe within 500 cycles");
    end
  endtask

  // Asynchronous reset issued from a falling edge, released one cycle later
  task automatic doReset(input logic flagLevel);
    areset  = 1'b1;
    enable  = 1'b0;
    ppsFlag = flagLevel;
    ppsAdd  = '0;
    #1;
    checkEq("reset_pps_out", longint'(ppsOut), 0);
    checkEq("reset_pps_stb", longint'(ppsStb), 0);
    checkEq("reset_sec_count", longint'(secCount), 0);
    checkEq("reset_adj_busy", longint'(adjBusy), 0);
    modelReset();
    @(negedge clk);
    areset = 1'b0;
  endtask

  initial begin
    int n;
    int guard;

    if (SLEW) begin
      vecs[0] = '{33'h0_0000_0007, 104, 103, 100, 100};
      vecs[1] = '{33'h1_0000_0005, 96, 99, 100, 100};
      vecs[2] = '{33'h1_0000_00C8, 96, 96, 96, 96};
      vecs[3] = '{33'h0_0000_0096, 104, 104, 104, 104};
    end else begin
      vecs[0] = '{33'h0_0000_0007, 107, 100, 100, 100};
      vecs[1] = '{33'h1_0000_0005, 95, 100, 100, 100};
      vecs[2] = '{33'h1_0000_00C8, 11, 11, 78, 100};
      vecs[3] = '{33'h0_0000_0096, 200, 150, 100, 100};
    end

    @(negedge clk);

    // Nominal seconds straight after reset
    doReset(1'b0);
    enable = 1'b1;
    waitStrobe(n);
    checkEq("first_strobe_latency", n, 1);
    for (int k = 0; k < 3; k++) begin
      waitStrobe(n);
      checkEq("nominal_period", n, CLK_HZ);
      checkEq("nominal_sec_count", longint'(secCount), k + 1);
    end

    // Single adjustment requests, measured as strobe intervals
    for (int v = 0; v < 4; v++) begin
      doReset(1'b0);
      enable = 1'b1;
      waitStrobe(n);
      repeat (30) applyStimulus();
      ppsFlag = ~ppsFlag;
      ppsAdd  = vecs[v].add;
      waitStrobe(n);
      checkEq("pre_adjust_second", n + 30, CLK_HZ);
      waitStrobe(n);
      checkEq("adjusted_len0", n, vecs[v].len0);
      waitStrobe(n);
      checkEq("adjusted_len1", n, vecs[v].len1);
      waitStrobe(n);
      checkEq("adjusted_len2", n, vecs[v].len2);
      waitStrobe(n);
      checkEq("adjusted_len3", n, vecs[v].len3);
    end

    // Request on the boundary cycle, then replaced before the next boundary
    doReset(1'b0);
    enable = 1'b1;
    waitStrobe(n);
    guard = 0;
    while (mPhase != mLen - 1 && guard < 300) begin
      applyStimulus();
      guard++;
    end
    ppsFlag = ~ppsFlag;
    ppsAdd  = 33'h0_0000_0003;
    applyStimulus();
    waitStrobe(n);
    checkEq("boundary_strobe_follows", n, 1);
    repeat (20) applyStimulus();
    ppsFlag = ~ppsFlag;
    ppsAdd  = 33'h0_0000_0002;
    waitStrobe(n);
    checkEq("boundary_old_pending_second", n + 20, 100);
    waitStrobe(n);
    checkEq("boundary_replaced_second", n, 102);
    waitStrobe(n);
    checkEq("boundary_after_replaced", n, 100);

    // Flag already high at reset release, then a reset that discards pending
    doReset(1'b1);
    enable = 1'b1;
    waitStrobe(n);
    waitStrobe(n);
    checkEq("flag_high_release_len0", n, 100);
    waitStrobe(n);
    checkEq("flag_high_release_len1", n, 100);
    ppsFlag = ~ppsFlag;
    ppsAdd  = 33'h0_0000_0032;
    repeat (15) applyStimulus();
    doReset(ppsFlag);
    enable = 1'b1;
    waitStrobe(n);
    checkEq("post_reset_first_strobe", n, 1);
    waitStrobe(n);
    checkEq("post_reset_len0", n, 100);
    waitStrobe(n);
    checkEq("post_reset_len1", n, 100);

    // Random enable gaps and requests against the model
    doReset(1'b0);
    enable = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if ($urandom_range(0, 119) == 0) begin
        ppsFlag = ~ppsFlag;
        ppsAdd  = {1'($urandom_range(0, 1)), 32'($urandom_range(0, 250))};
      end
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
